// File: rtl/pc_sequencer_pkg.sv
// Shared ISA and sequencer definitions: opcodes, PC source selects, FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    typedef logic [2:0] opcode_t;
    typedef logic [1:0] pcsrc_t;

    localparam opcode_t OP_RALU = 3'b000;
    localparam opcode_t OP_IALU = 3'b001;
    localparam opcode_t OP_LW   = 3'b010;
    localparam opcode_t OP_SW   = 3'b011;
    localparam opcode_t OP_BEQ  = 3'b100;
    localparam opcode_t OP_JMP  = 3'b101;
    localparam opcode_t OP_RSVD = 3'b110;
    localparam opcode_t OP_HALT = 3'b111;

    localparam pcsrc_t PCSRC_SEQ = 2'b00;  // PC+2
    localparam pcsrc_t PCSRC_BRN = 2'b01;  // PC+2+ExtBrnImm
    localparam pcsrc_t PCSRC_JMP = 2'b10;  // {PC[15:14],absjmp,0}

    // Timeout limit is 1..255, so 8 bits covers the saturated count.
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // States in which a memory handshake is outstanding and the bus timer runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of sequencer <-> IMEM/DMEM/datapath control signals.
// Latency: n/a (wires only).
// Backpressure: req/ack handshakes on IMEM and DMEM; stall holds the internal stages.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic        stall;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr_in;
    logic        ir_we;
    logic        zero;
    logic        pc_we;
    pcsrc_t      pc_src;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        reg_we;
    logic        mem_to_reg;
    logic        halted;
    logic        bus_err;
    logic        illegal_op;
    logic [15:0] retired;

    // Sequencer side.
    modport master (
        input  stall, imem_ack, instr_in, zero, dmem_ack,
        output imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
               reg_we, mem_to_reg, halted, bus_err, illegal_op, retired
    );

    // Memory / datapath side.
    modport slave (
        output stall, imem_ack, instr_in, zero, dmem_ack,
        input  imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
               reg_we, mem_to_reg, halted, bus_err, illegal_op, retired
    );

endinterface

// File: rtl/pc_sequencer_bus_timer.sv
// Saturating wait-cycle counter for the outstanding memory handshake; flags timeout.
// Latency: timeout flag is a combinational decode of the registered count.
// Backpressure: none; counts while enabled, clear has priority over enable.
module pc_sequencer_bus_timer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [TIMER_W-1:0] LIMIT    = TIMER_W'(MEM_TIMEOUT);
    localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] r_cnt;

    // Count waiting cycles, clearing when no handshake is pending or it completes.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + TIMER_W'(1);
        end
    end

    // The cycle holding count MEM_TIMEOUT-1 is the last one an ack may arrive in.
    assign o_timeout = (r_cnt >= LIMIT_M1);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback with halt, trap and bus timeout.
// Latency: CPI 3 (BEQ/JMP), 4 (R/I/SW), 5 (LW) with zero-wait acks; strobes are same-cycle.
// Backpressure: waits on imem_ack/dmem_ack (bounded by MEM_TIMEOUT); stall freezes DECODE/EXEC/WB.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pc_sequencer_if.master io_bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    opcode_t     r_op;
    logic [15:0] r_retired;
    logic        r_bus_err;
    logic        r_illegal;

    logic        w_ir_we;
    logic        w_pc_we;
    pcsrc_t      w_pc_src;
    logic        w_reg_we;
    logic        w_retire;
    logic        w_set_bus_err;
    logic        w_set_illegal;
    logic        w_wait;
    logic        w_ack;
    logic        w_timeout;
    logic        w_unused_bits;

    // Only the opcode field steers sequencing; operand bits go to the datapath via the IR.
    assign w_unused_bits = ^io_bus.instr_in[12:0];

    assign w_wait = is_wait_state(r_state);
    assign w_ack  = ((r_state == ST_FETCH) && io_bus.imem_ack) ||
                    ((r_state == ST_MEM)   && io_bus.dmem_ack);

    pc_sequencer_bus_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_bus_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (!w_wait || w_ack),
        .i_en      (w_wait),
        .o_timeout (w_timeout)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and same-cycle strobes; stall only freezes the internal stages.
    always_comb begin
        w_state_nxt   = r_state;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_src      = PCSRC_SEQ;
        w_reg_we      = 1'b0;
        w_retire      = 1'b0;
        w_set_bus_err = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (io_bus.imem_ack) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_state_nxt   = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (!io_bus.stall) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!io_bus.stall) begin
                    case (r_op)
                        OP_RALU, OP_IALU: w_state_nxt = ST_WB;
                        OP_LW, OP_SW:     w_state_nxt = ST_MEM;
                        OP_BEQ: begin
                            w_pc_we     = 1'b1;
                            w_pc_src    = io_bus.zero ? PCSRC_BRN : PCSRC_SEQ;
                            w_retire    = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                        OP_JMP: begin
                            w_pc_we     = 1'b1;
                            w_pc_src    = PCSRC_JMP;
                            w_retire    = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                        OP_HALT: begin
                            w_retire    = 1'b1;
                            w_state_nxt = ST_HALT;
                        end
                        default: begin
                            w_set_illegal = 1'b1;
                            w_state_nxt   = ST_ERROR;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (io_bus.dmem_ack) begin
                    if (r_op == OP_SW) begin
                        w_pc_we     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_state_nxt   = ST_ERROR;
                end
            end
            ST_WB: begin
                if (!io_bus.stall) begin
                    w_reg_we    = 1'b1;
                    w_pc_we     = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT, ST_ERROR: w_state_nxt = r_state;
            default:           w_state_nxt = ST_ERROR;
        endcase
    end

    // Opcode latch, loaded alongside the IR capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op <= OP_RALU;
        end else if (w_ir_we) begin
            r_op <= io_bus.instr_in[15:13];
        end
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retired <= 16'h0000;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'h0001;
        end
    end

    // Sticky fault flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bus_err <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_set_bus_err) r_bus_err <= 1'b1;
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    // Outputs are held low while reset is asserted, regardless of the state register.
    assign io_bus.imem_req   = !i_rst && (r_state == ST_FETCH);
    assign io_bus.ir_we      = !i_rst && w_ir_we;
    assign io_bus.pc_we      = !i_rst && w_pc_we;
    assign io_bus.pc_src     = i_rst ? PCSRC_SEQ : w_pc_src;
    assign io_bus.dmem_req   = !i_rst && (r_state == ST_MEM);
    assign io_bus.dmem_we    = !i_rst && (r_state == ST_MEM) && (r_op == OP_SW);
    assign io_bus.reg_we     = !i_rst && w_reg_we;
    assign io_bus.mem_to_reg = !i_rst && (r_state == ST_WB) && (r_op == OP_LW);
    assign io_bus.halted     = !i_rst && (r_state == ST_HALT);
    assign io_bus.bus_err    = !i_rst && r_bus_err;
    assign io_bus.illegal_op = !i_rst && r_illegal;
    assign io_bus.retired    = i_rst ? 16'h0000 : r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer plus directed halt/trap/timeout/reset cases.
// Latency: expected completion cycle per instruction computed from opcode and wait counts.
// Backpressure: bench acts as IMEM/DMEM with random ack delays and random stall windows.
module tb_pc_sequencer;

    localparam int NUM_RAND = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .MEM_TIMEOUT (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       m2r;
        logic       dwe;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".imem_req"},   32'(bus.imem_req),   0);
        chk({tag, ".ir_we"},      32'(bus.ir_we),      0);
        chk({tag, ".pc_we"},      32'(bus.pc_we),      0);
        chk({tag, ".pc_src"},     32'(bus.pc_src),     0);
        chk({tag, ".dmem_req"},   32'(bus.dmem_req),   0);
        chk({tag, ".dmem_we"},    32'(bus.dmem_we),    0);
        chk({tag, ".reg_we"},     32'(bus.reg_we),     0);
        chk({tag, ".mem_to_reg"}, 32'(bus.mem_to_reg), 0);
        chk({tag, ".halted"},     32'(bus.halted),     0);
        chk({tag, ".bus_err"},    32'(bus.bus_err),    0);
        chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 0);
        chk({tag, ".retired"},    32'(bus.retired),    0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // IMEM responder: wait for the request, delay wf cycles, then ack with the word.
    task automatic do_fetch(input logic [15:0] ins, input int wf, input logic z);
        int k = 0;
        while (!bus.imem_req && k < 40) begin
            tick();
            k++;
        end
        chk("fetch_req_seen", 32'(bus.imem_req), 1);
        repeat (wf) tick();
        bus.imem_ack = 1'b1;
        bus.instr_in = ins;
        bus.zero     = z;
        tick();
        bus.imem_ack = 1'b0;
        bus.instr_in = 16'($urandom);
    endtask

    // DMEM responder.
    task automatic do_mem(input int wm);
        int k = 0;
        while (!bus.dmem_req && k < 40) begin
            tick();
            k++;
        end
        chk("dmem_req_seen", 32'(bus.dmem_req), 1);
        repeat (wm) tick();
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
    endtask

    // Reference: expected strobes and total cycles, from the opcode's stage list.
    task automatic run_instr(input logic [2:0] op, input int wf, input int wm,
                             input int st, input int sd, input logic z);
        exp_t e;
        int   base;
        base     = (wf + 1) + 1 + st + 1;   // fetch waits+ack, decode, stall, exec
        e.pc_we  = 1'b1;
        e.pc_src = 2'b00;
        e.reg_we = 1'b0;
        e.m2r    = 1'b0;
        e.dwe    = (op == 3'b011);
        e.lat    = base;
        case (op)
            3'b000, 3'b001: begin e.reg_we = 1'b1; e.lat = base + 1; end
            3'b010: begin e.reg_we = 1'b1; e.m2r = 1'b1; e.lat = base + (wm + 1) + 1; end
            3'b011: e.lat = base + (wm + 1);
            3'b100: e.pc_src = z ? 2'b01 : 2'b00;
            3'b101: e.pc_src = 2'b10;
            default: e.lat = 0;
        endcase
        q.push_back(e);
        do_fetch({op, 13'($urandom)}, wf, z);
        if (sd != 0) tick();
        if (st > 0) begin
            bus.stall = 1'b1;
            repeat (st) tick();
            bus.stall = 1'b0;
        end
        if (op == 3'b010 || op == 3'b011) do_mem(wm);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a PC or register strobe.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            cyc    = 0;
            n_done = 0;
        end else begin
            cyc++;
            if (!bus.pc_we) chk("pc_src_idle", 32'(bus.pc_src), 0);
            if (bus.ir_we || (bus.imem_req && bus.imem_ack))
                chk("ir_we_on_ack", 32'(bus.ir_we), 1);
            if (bus.dmem_req && q.size() > 0)
                chk("dmem_we", 32'(bus.dmem_we), 32'(q[0].dwe));
            if (bus.pc_we || bus.reg_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, bus.pc_we, bus.reg_we}, 0);
                end else begin
                    e = q.pop_front();
                    chk("pc_we",      32'(bus.pc_we),      32'(e.pc_we));
                    chk("pc_src",     32'(bus.pc_src),     32'(e.pc_src));
                    chk("reg_we",     32'(bus.reg_we),     32'(e.reg_we));
                    chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.m2r));
                    chk("latency",    32'(cyc),            32'(e.lat));
                    chk("retired",    32'(bus.retired),    32'(n_done));
                    chk("sticky_clear", {29'd0, bus.halted, bus.bus_err, bus.illegal_op}, 0);
                    n_done++;
                end
                cyc = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int k;
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.instr_in = 16'h0000;
        bus.zero     = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick();
        check_all_zero("reset");
        do_reset();
        chk("fetch_after_reset", 32'(bus.imem_req), 1);

        // Randomized instruction stream over the legal non-halt opcodes.
        for (int i = 0; i < NUM_RAND; i++) begin
            run_instr(3'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 5), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end
        k = 0;
        while (q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk("drain", 32'(q.size()), 0);

        // HALT retires without a PC update and parks the FSM.
        do_fetch({3'b111, 13'h0ABC}, 0, 1'b0);
        repeat (3) tick();
        chk("halted",        32'(bus.halted),   1);
        chk("halt_retired",  32'(bus.retired),  32'(NUM_RAND + 1));
        chk("halt_no_fetch", 32'(bus.imem_req), 0);
        repeat (3) tick();
        chk("halted_sticky", 32'(bus.halted),   1);
        chk("halt_bus_err",  32'(bus.bus_err),  0);

        // Reserved opcode traps.
        do_reset();
        do_fetch({3'b110, 13'h0123}, 1, 1'b0);
        repeat (3) tick();
        chk("illegal_op",      32'(bus.illegal_op), 1);
        chk("illegal_bus_err", 32'(bus.bus_err),    0);
        chk("illegal_halted",  32'(bus.halted),     0);
        chk("illegal_no_req",  32'(bus.imem_req),   0);
        chk("illegal_retired", 32'(bus.retired),    0);

        // Fetch timeout: 16 unacknowledged cycles, then ERROR.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            chk("to_wait_req", 32'(bus.imem_req), 1);
            chk("to_wait_err", 32'(bus.bus_err),  0);
            tick();
        end
        chk("timeout_bus_err", 32'(bus.bus_err),  1);
        chk("timeout_no_req",  32'(bus.imem_req), 0);
        repeat (4) tick();
        chk("timeout_err_sticky", 32'(bus.bus_err),  1);
        chk("timeout_req_stays0", 32'(bus.imem_req), 0);

        // Reset in the middle of a data access.
        do_reset();
        do_fetch({3'b010, 13'h0042}, 0, 1'b0);
        k = 0;
        while (!bus.dmem_req && k < 10) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("mem_waiting", 32'(bus.dmem_req), 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_mem");
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_fetch",   32'(bus.imem_req), 1);
        chk("post_rst_dmem",    32'(bus.dmem_req), 0);
        chk("post_rst_retired", 32'(bus.retired),  0);
        chk("post_rst_bus_err", 32'(bus.bus_err),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
